// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_redirect_ctrl_pkg: shared types and constants for the fetch-stage PC sequencer.
// XLEN is fixed here so the redirect record can be a packed struct shared by every file.
package fetch_redirect_ctrl_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {BOOT, RUN, WAIT} state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_EXE, SRC_TRAP} redir_src_e;

    typedef struct packed {
        logic             valid;
        redir_src_e       src;
        logic [XLEN-1:0]  target;
    } redir_t;
endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// fetch_redirect_ctrl_if: instruction-memory request/grant handshake.
interface fetch_redirect_ctrl_if;
    import fetch_redirect_ctrl_pkg::*;
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    modport master (output req, output addr, input gnt);
    modport slave  (input req, input addr, output gnt);
endinterface

// File: rtl/fetch_redirect_ctrl_redirect_arb.sv
// fetch_redirect_ctrl_redirect_arb: picks the redirect to apply and computes the next pending record.
module fetch_redirect_ctrl_redirect_arb
    import fetch_redirect_ctrl_pkg::*;
(
    input  redir_t          pend_i,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            exe_flag_i,
    input  logic [XLEN-1:0] exe_target_i,
    output redir_t          sel_o,
    output redir_t          capture_o
);
    redir_t trap_r, exe_r;
    always_comb begin
        trap_r    = '{valid: 1'b1, src: SRC_TRAP, target: trap_vector_i};
        exe_r     = '{valid: 1'b1, src: SRC_EXE, target: exe_target_i};
        sel_o     = pend_i.valid ? pend_i : trap_req_i ? trap_r : exe_flag_i ? exe_r : '0;
        // A buffered trap is never displaced by a later execute redirect.
        capture_o = trap_req_i ? trap_r :
                    (exe_flag_i && !(pend_i.valid && pend_i.src == SRC_TRAP)) ? exe_r : pend_i;
    end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: fetch PC sequencer with imem handshake, redirect buffering and IF/ID flush.
// Handshake outputs are combinational in the inputs so a grant or redirect acts in the same cycle.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  exe_redirect_flag_i,
    input  logic [XLEN-1:0]       exe_redirect_target_i,
    input  logic                  trap_req_i,
    input  logic [XLEN-1:0]       trap_vector_i,
    fetch_redirect_ctrl_if.master imem,
    output logic [XLEN-1:0]       pc_o,
    output logic                  pc_write_o,
    output logic                  pc_src_o,
    output logic                  flush_o,
    output logic [CNT_W-1:0]      redirect_cnt_o
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    redir_t          pend_q, sel, capture;
    logic [FW-1:0]   flush_q;
    logic [CNT_W-1:0] cnt_q;
    logic            apply, fetch;

    fetch_redirect_ctrl_redirect_arb u_arb (
        .pend_i        (pend_q),
        .trap_req_i    (trap_req_i),
        .trap_vector_i (trap_vector_i),
        .exe_flag_i    (exe_redirect_flag_i),
        .exe_target_i  (exe_redirect_target_i),
        .sel_o         (sel),
        .capture_o     (capture)
    );

    assign apply          = state_q == RUN && sel.valid;
    assign fetch          = state_q == WAIT || (state_q == RUN && !sel.valid && !stall_i);
    assign imem.req       = !rst && fetch;
    assign imem.addr      = pc_q;
    assign pc_write_o     = !rst && (apply || (fetch && imem.gnt));
    assign pc_src_o       = !rst && apply;
    assign flush_o        = !rst && flush_q != '0;
    assign pc_o           = pc_q;
    assign redirect_cnt_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            flush_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_q == BOOT ? RUN :
                       state_q == RUN  ? ((sel.valid || stall_i || imem.gnt) ? RUN : WAIT) :
                       (imem.gnt ? RUN : WAIT);
            if (apply)
                pc_q <= sel.target & ~XLEN'(INSTR_BYTES - 1);
            else if (fetch && imem.gnt)
                pc_q <= pc_q + XLEN'(INSTR_BYTES);
            // In RUN any pending record is consumed by apply, so only BOOT/WAIT buffer redirects.
            pend_q  <= state_q == RUN ? '0 : capture;
            flush_q <= apply ? FW'(FLUSH_CYCLES) : flush_q - FW'(flush_q != '0);
            if (apply && sel.src == SRC_EXE && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule
